// File: rtl/ysyx_24110015_ifu_prefetch.sv
// Instruction fetch unit: one outstanding memory request, DEPTH-entry prefetch
// FIFO toward the IDU, redirect flushes the FIFO and drops any stale response.
module ysyx_24110015_ifu_prefetch #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              rsp_valid,
    input  logic [INST_W-1:0] rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  flight_pc;
    logic [CNT_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [ADDR_W-1:0]  pc_mem   [DEPTH];
    logic [INST_W-1:0]  inst_mem [DEPTH];

    logic fire_req;
    logic push;
    logic pop;

    // Issue only from IDLE with FIFO room; redirect and reset suppress issue
    assign req_valid = (state == S_IDLE) && (count < CNT_W'(DEPTH)) && !redirect_valid && !rst;
    assign req_addr  = fetch_pc;
    assign fire_req  = req_valid && req_ready;
    assign push      = (state == S_WAIT) && rsp_valid && !redirect_valid;
    assign out_valid = (count != '0) && !rst;
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign out_pc    = pc_mem[rd_ptr[PTR_W-1:0]];
    assign out_inst  = inst_mem[rd_ptr[PTR_W-1:0]];

    // Next-state: track the single outstanding request and whether it is stale
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (fire_req) state_n = S_WAIT;
            S_WAIT: begin
                if (rsp_valid)           state_n = S_IDLE;
                else if (redirect_valid) state_n = S_DROP;
            end
            S_DROP: if (rsp_valid) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State, fetch PC and FIFO bookkeeping; redirect wins over push/pop/issue
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC & ALIGN_MASK;
            flight_pc <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            state <= state_n;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ALIGN_MASK;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (fire_req) begin
                    flight_pc <= fetch_pc;
                    fetch_pc  <= fetch_pc + ADDR_W'(4);
                end
                if (push) wr_ptr <= wr_ptr + CNT_W'(1);
                if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // FIFO storage; contents are only meaningful below count
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr[PTR_W-1:0]]   <= flight_pc;
            inst_mem[wr_ptr[PTR_W-1:0]] <= rsp_data;
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_ifu_prefetch.sv
// Directed and randomized checks for the prefetching IFU with a latency-controlled memory model.
module tb_ysyx_24110015_ifu_prefetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    ysyx_24110015_ifu_prefetch dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // memory model state
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    int          lat = 1;
    logic        rand_lat = 1'b0;

    // per-cycle samples taken just before the active edge
    logic        s_rv, s_ov, s_fire, s_pop;
    logic [31:0] s_addr, s_pc, s_inst;

    typedef struct {
        logic        rdy;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive memory response, sample outputs, advance the model
    task automatic step();
        rsp_valid = pend && (cnt == 0);
        rsp_data  = ~paddr;
        #1;
        s_rv   = req_valid;
        s_addr = req_addr;
        s_ov   = out_valid;
        s_pc   = out_pc;
        s_inst = out_inst;
        s_fire = req_valid && req_ready;
        s_pop  = out_valid && out_ready;
        @(posedge clk);
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (rsp_valid) pend = 1'b0;
            else if (pend && cnt != 0) cnt--;
            if (s_fire) begin
                pend  = 1'b1;
                paddr = s_addr;
                cnt   = rand_lat ? int'($urandom_range(0, 4)) : lat - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        step();
        chk("rst_req_valid0", 32'(s_rv), 32'd0);
        chk("rst_out_valid0", 32'(s_ov), 32'd0);
        step();
        chk("rst_req_valid1", 32'(s_rv), 32'd0);
        chk("rst_out_valid1", 32'(s_ov), 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_out(input string name, input logic [31:0] exp_pc);
        logic seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (s_ov) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({name, "_pc"}, s_pc, exp_pc);
            chk({name, "_inst"}, s_inst, ~exp_pc);
        end
    endtask

    initial begin
        int n;
        int pops;
        logic [31:0] a;
        logic seen;
        logic bad;
        logic [31:0] exp_fetch, exp_out;

        rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

        //            rdy  e_rv  e_addr          e_ov  e_pc
        tbl[0] = '{1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000};
        tbl[3] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004};
        tbl[5] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0008};

        @(negedge clk);

        // 1-cycle memory streaming after reset
        do_reset();
        lat = 1; req_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            out_ready = tbl[i].rdy;
            step();
            chk($sformatf("seq_req_valid[%0d]", i), 32'(s_rv), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk($sformatf("seq_req_addr[%0d]", i), s_addr, tbl[i].e_addr);
            chk($sformatf("seq_out_valid[%0d]", i), 32'(s_ov), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk($sformatf("seq_out_pc[%0d]", i), s_pc, tbl[i].e_pc);
                chk($sformatf("seq_out_inst[%0d]", i), s_inst, ~tbl[i].e_pc);
            end
        end

        // Backpressure fills the FIFO; one pop frees exactly one fetch
        do_reset();
        out_ready = 1'b0; lat = 1; req_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_fire) n++;
        end
        chk("full_req_count", 32'(n), 32'd4);
        chk("full_req_valid", 32'(s_rv), 32'd0);
        chk("full_out_valid", 32'(s_ov), 32'd1);
        out_ready = 1'b1;
        step();
        chk("full_pop", 32'(s_pop), 32'd1);
        chk("full_pop_pc", s_pc, 32'h8000_0000);
        out_ready = 1'b0;
        n = 0; a = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_fire) begin
                n++;
                a = s_addr;
            end
        end
        chk("refill_req_count", 32'(n), 32'd1);
        chk("refill_req_addr", a, 32'h8000_0010);

        // Redirect while a slow request is in flight
        do_reset();
        out_ready = 1'b1; req_ready = 1'b1; lat = 4;
        step();
        chk("drop_first_fire", 32'(s_fire), 32'd1);
        lat = 1;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_1002;
        step();
        redirect_valid = 1'b0;
        seen = 1'b0; bad = 1'b0; n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (s_ov) bad = 1'b1;
            if (s_fire) begin
                seen = 1'b1;
                break;
            end
        end
        chk("drop_no_out", 32'(bad), 32'd0);
        chk("drop_refetch_seen", 32'(seen), 32'd1);
        chk("drop_refetch_addr", s_addr, 32'h8000_1000);
        chk("drop_refetch_cycle", 32'(n), 32'd4);
        wait_out("drop_out", 32'h8000_1000);

        // Redirect coinciding with response and IDU handshake, FIFO holding 2
        do_reset();
        out_ready = 1'b0; req_ready = 1'b1; lat = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_fire) n++;
            if (n == 3) break;
        end
        chk("coin_fires", 32'(n), 32'd3);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h9000_0000;
        step();
        chk("coin_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("coin_head_pc", s_pc, 32'h8000_0000);
        redirect_valid = 1'b0;
        step();
        chk("coin_out_valid", 32'(s_ov), 32'd0);
        chk("coin_req_valid", 32'(s_rv), 32'd1);
        chk("coin_req_addr", s_addr, 32'h9000_0000);
        wait_out("coin_out", 32'h9000_0000);

        // Random stalls, latency and redirects against a sequential-PC scoreboard
        do_reset();
        rand_lat = 1'b1;
        exp_fetch = RST_PC; exp_out = RST_PC; pops = 0;
        for (int i = 0; i < 3000; i++) begin
            req_ready = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc = $urandom;
            step();
            if (s_fire) begin
                chk("rnd_req_addr", s_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (s_pop && !redirect_valid) begin
                chk("rnd_out_pc", s_pc, exp_out);
                chk("rnd_out_inst", s_inst, ~exp_out);
                exp_out = exp_out + 32'd4;
                pops++;
            end
            if (redirect_valid) begin
                exp_fetch = redirect_pc & ~32'd3;
                exp_out   = redirect_pc & ~32'd3;
            end
        end
        redirect_valid = 1'b0;
        rand_lat = 1'b0;
        chk("rnd_enough_pops", 32'(pops > 150), 32'd1);

        // Reset with a mostly full FIFO and a request in flight
        do_reset();
        out_ready = 1'b0; req_ready = 1'b1; lat = 3;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (s_fire) n++;
            if (n == 4) break;
        end
        chk("rst_fill_fires", 32'(n), 32'd4);
        rst = 1'b1;
        step();
        chk("midrst_req_valid0", 32'(s_rv), 32'd0);
        chk("midrst_out_valid0", 32'(s_ov), 32'd0);
        step();
        chk("midrst_req_valid1", 32'(s_rv), 32'd0);
        chk("midrst_out_valid1", 32'(s_ov), 32'd0);
        rst = 1'b0;
        step();
        chk("postrst_req_valid", 32'(s_rv), 32'd1);
        chk("postrst_req_addr", s_addr, RST_PC);
        chk("postrst_out_valid", 32'(s_ov), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
